// File: rtl/edge_detect_pkg.sv
// Shared constants for edge_detect_mc: per-channel mode encoding and parameter limits.
package edge_detect_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 32;
  localparam int SYNC_MIN     = 2;
  localparam int SYNC_MAX     = 4;
  localparam int FILT_CYC_MIN = 1;
  localparam int FILT_CYC_MAX = 255;

  function automatic logic rise_enabled(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic fall_enabled(input logic [1:0] m);
    return (m != MODE_OFF) && (m != MODE_RISE);
  endfunction

endpackage

// File: rtl/edge_detect_mc_edge_filt.sv
// One channel: synchroniser, optional glitch filter (EDGE_DETECT_MC_FILT_EN), edge registers.
module edge_filt
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef EDGE_DETECT_MC_FILT_EN
  , parameter int FILT_CYC  = 4
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pulse,
  input  logic [1:0] mode,
  output logic       pos_edge,
  output logic       neg_edge,
  output logic       level,
  output logic       evt_set
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_lvl;
  logic                   level_reg;
  logic                   rise_det;
  logic                   fall_det;
  logic                   pos_next;
  logic                   neg_next;
  logic                   pos_edge_reg;
  logic                   neg_edge_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pulse};
    end
  end

  assign sync_lvl = sync_reg[SYNC_STAGES-1];

`ifdef EDGE_DETECT_MC_FILT_EN
  localparam logic [7:0] FILT_LAST = 8'(FILT_CYC - 1);

  logic [7:0] cnt_reg;
  logic       level_d_reg;

  // Level flips on the FILT_CYC-th consecutive cycle of disagreement; edges come one cycle later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
    end else begin
      level_d_reg <= level_reg;
      if (sync_lvl == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == FILT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= sync_lvl;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign rise_det = level_reg & ~level_d_reg;
  assign fall_det = ~level_reg & level_d_reg;
`else
  // Unfiltered: edges are registered alongside the level so latency stays SYNC_STAGES.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      level_reg <= 1'b0;
    end else begin
      level_reg <= sync_lvl;
    end
  end

  assign rise_det = sync_lvl & ~level_reg;
  assign fall_det = ~sync_lvl & level_reg;
`endif

  assign pos_next = rise_det & rise_enabled(mode);
  assign neg_next = fall_det & fall_enabled(mode);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pos_edge_reg <= 1'b0;
      neg_edge_reg <= 1'b0;
    end else begin
      pos_edge_reg <= pos_next;
      neg_edge_reg <= neg_next;
    end
  end

  assign pos_edge = pos_edge_reg;
  assign neg_edge = neg_edge_reg;
  assign level    = level_reg;
  assign evt_set  = pos_next | neg_next;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector with sticky event flags and irq; filter enabled by EDGE_DETECT_MC_FILT_EN.
module edge_detect_mc
  import edge_detect_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [WIDTH-1:0]   pulse,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   evt_clr,
  output logic [WIDTH-1:0]   pos_edge,
  output logic [WIDTH-1:0]   neg_edge,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   evt_pend,
  output logic               irq
);

  logic [WIDTH-1:0] evt_set;
  logic [WIDTH-1:0] evt_pend_reg;
  logic             irq_reg;

  // Out-of-range parameters leave a visibly named block in the elaborated hierarchy.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync_stages
  end
  if (FILT_CYC < FILT_CYC_MIN || FILT_CYC > FILT_CYC_MAX) begin : g_bad_filt_cyc
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    edge_filt #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_DETECT_MC_FILT_EN
      , .FILT_CYC  (FILT_CYC)
`endif
    ) u_edge_filt (
      .clk      (clk),
      .rstn     (rstn),
      .pulse    (pulse[gi]),
      .mode     (mode[2*gi +: 2]),
      .pos_edge (pos_edge[gi]),
      .neg_edge (neg_edge[gi]),
      .level    (level[gi]),
      .evt_set  (evt_set[gi])
    );
  end

  // A new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      evt_pend_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      evt_pend_reg <= (evt_pend_reg & ~evt_clr) | evt_set;
      irq_reg      <= |evt_pend_reg;
    end
  end

  assign evt_pend = evt_pend_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed self-checking bench for edge_detect_mc (default parameters, either filter build).
module tb_edge_detect_mc;

`ifdef EDGE_DETECT_MC_FILT_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 6;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 2;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  pulse;
  logic [15:0] mode;
  logic [7:0]  evt_clr;
  logic [7:0]  pos_edge;
  logic [7:0]  neg_edge;
  logic [7:0]  level;
  logic [7:0]  evt_pend;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  edge_detect_mc dut (
    .clk      (clk),
    .rstn     (rstn),
    .pulse    (pulse),
    .mode     (mode),
    .evt_clr  (evt_clr),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge),
    .level    (level),
    .evt_pend (evt_pend),
    .irq      (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    evt_clr = '1;
    tick();
    evt_clr = '0;
    tick();
    tick();
  endtask

  // Pulse a channel high for n cycles, then watch 20 cycles; count edges and note any level high.
  task automatic pulse_run(input int ch, input int n, output int pc, output int nc, output bit ls);
    pc = 0;
    nc = 0;
    ls = 1'b0;
    pulse[ch] = 1'b1;
    for (int k = 0; k < n + 20; k++) begin
      if (k == n) pulse[ch] = 1'b0;
      tick();
      pc += int'(pos_edge[ch]);
      nc += int'(neg_edge[ch]);
      ls |= level[ch];
    end
  endtask

  initial begin
    int  pc, nc;
    bit  ls;
    int  pcnt [8];
    logic [7:0] any_pos, any_neg;

    rstn    = 1'b0;
    pulse   = '0;
    mode    = '1;
    evt_clr = '0;
    repeat (3) tick();
    $display("[TB] reset state (filter=%0d)", FILT);
    chk("rst_pos", pos_edge, 0);
    chk("rst_neg", neg_edge, 0);
    chk("rst_level", level, 0);
    chk("rst_pend", evt_pend, 0);
    chk("rst_irq", irq, 0);
    rstn = 1'b1;
    tick();

    // Rising edge latency on channel 0
    $display("[TB] ch0 rise latency, expect pos_edge %0d cycles after first sample", LAT);
    pulse[0] = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      chk($sformatf("lat_pos_c%0d", c), pos_edge[0], (c == LAT + 1));
      chk($sformatf("lat_neg_c%0d", c), neg_edge[0], 0);
    end
    chk("lat_level", level[0], 1);
    chk("lat_pend", evt_pend[0], 1);
    chk("lat_irq", irq, 1);
    clear_all();

    // Short glitch and minimum valid pulse on channel 1
    pulse_run(1, 3, pc, nc, ls);
    $display("[TB] ch1 3-cycle glitch: pos=%0d neg=%0d level_seen=%0d", pc, nc, ls);
    chk("glitch_pos", pc, FILT ? 0 : 1);
    chk("glitch_neg", nc, FILT ? 0 : 1);
    chk("glitch_level", ls, FILT ? 0 : 1);
    pulse_run(1, 4, pc, nc, ls);
    $display("[TB] ch1 4-cycle pulse: pos=%0d neg=%0d", pc, nc);
    chk("p4_pos", pc, 1);
    chk("p4_neg", nc, 1);
    chk("p4_level_end", level[1], 0);
    clear_all();

    // Mode selection on channel 2
    mode[5:4] = 2'b10;
    pulse_run(2, 8, pc, nc, ls);
    $display("[TB] ch2 mode=10: pos=%0d neg=%0d", pc, nc);
    chk("fall_pos", pc, 0);
    chk("fall_neg", nc, 1);
    chk("fall_pend", evt_pend[2], 1);
    clear_all();
    mode[5:4] = 2'b11;
    pulse_run(2, 8, pc, nc, ls);
    $display("[TB] ch2 mode=11: pos=%0d neg=%0d", pc, nc);
    chk("both_pos", pc, 1);
    chk("both_neg", nc, 1);
    clear_all();
    mode[5:4] = 2'b00;
    pulse_run(2, 8, pc, nc, ls);
    $display("[TB] ch2 mode=00: pos=%0d neg=%0d level_seen=%0d", pc, nc, ls);
    chk("off_pos", pc, 0);
    chk("off_neg", nc, 0);
    chk("off_pend", evt_pend[2], 0);
    chk("off_level_seen", ls, 1);
    chk("off_irq", irq, 0);

    // Clear coinciding with a new event on channel 3, then clear alone
    $display("[TB] ch3 clear vs set");
    pulse[3] = 1'b1;
    repeat (LAT) tick();
    evt_clr[3] = 1'b1;
    tick();
    evt_clr[3] = 1'b0;
    chk("coin_pos", pos_edge[3], 1);
    chk("coin_pend", evt_pend[3], 1);
    tick();
    chk("coin_pend_hold", evt_pend[3], 1);
    chk("coin_irq", irq, 1);
    evt_clr[3] = 1'b1;
    tick();
    evt_clr[3] = 1'b0;
    chk("clr_pend", evt_pend[3], 0);
    chk("clr_irq_lag", irq, 1);
    tick();
    chk("clr_irq", irq, 0);

    // All inputs high through reset
    $display("[TB] all-ones through reset");
    mode  = '1;
    pulse = '1;
    rstn  = 1'b0;
    repeat (4) tick();
    chk("hr_pos", pos_edge, 0);
    chk("hr_neg", neg_edge, 0);
    chk("hr_level", level, 0);
    chk("hr_pend", evt_pend, 0);
    chk("hr_irq", irq, 0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) pcnt[i] = 0;
    any_neg = '0;
    repeat (LAT + 6) begin
      tick();
      for (int i = 0; i < 8; i++) pcnt[i] += int'(pos_edge[i]);
      any_neg |= neg_edge;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("hr_pos_cnt%0d", i), pcnt[i], 1);
    chk("hr_any_neg", any_neg, 0);
    chk("hr_level_after", level, 8'hff);
    chk("hr_pend_after", evt_pend, 8'hff);

    // Reset in the middle of a falling-edge filter count
    $display("[TB] reset mid-filter");
    pulse = '0;
    any_pos = '0;
    any_neg = '0;
    repeat (FILT ? 4 : 1) begin
      tick();
      any_neg |= neg_edge;
    end
    chk("mid_no_neg_yet", any_neg, 0);
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (20) begin
      tick();
      any_pos |= pos_edge;
      any_neg |= neg_edge;
    end
    chk("mid_pos", any_pos, 0);
    chk("mid_neg", any_neg, 0);
    chk("mid_level", level, 0);
    chk("mid_pend", evt_pend, 0);
    chk("mid_irq", irq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/edge_detect_mc.md
EDGE_DETECT_MC -- requirements
Module: edge_detect_mc

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the number of independent input channels (1..32).
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2, giving the synchroniser depth per channel (2..4).
REQ-003 The block SHALL take parameter FILT_CYC, default 4, giving the glitch-filter stability count in cycles (1..255).
REQ-004 Port clk SHALL be input, 1 bit: the single clock; all flops are rising-edge clocked.
REQ-005 Port rstn SHALL be input, 1 bit: synchronous, active-low reset.
REQ-006 Port pulse SHALL be input, WIDTH bits: asynchronous level inputs, one per channel.
REQ-007 Port mode SHALL be input, 2*WIDTH bits: per-channel mode, 00 off, 01 rising, 10 falling, 11 both.
REQ-008 Port evt_clr SHALL be input, WIDTH bits: write-1-to-clear strobes for evt_pend.
REQ-009 Port pos_edge SHALL be output, WIDTH bits: registered one-cycle rising-edge pulses.
REQ-010 Port neg_edge SHALL be output, WIDTH bits: registered one-cycle falling-edge pulses.
REQ-011 Port level SHALL be output, WIDTH bits: the current filtered level per channel.
REQ-012 Port evt_pend SHALL be output, WIDTH bits: sticky per-channel event flags.
REQ-013 Port irq SHALL be output, 1 bit: registered OR of all evt_pend bits.

Function
REQ-014 Each pulse bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronised level.
REQ-015 When the synchronised level differs from level for FILT_CYC consecutive cycles, level SHALL take the new value on the next edge; any cycle of agreement SHALL reset that channel's 8-bit counter to 0.
REQ-016 A pulse of fewer than FILT_CYC synchronised cycles SHALL produce no level change and no edge.
REQ-017 pos_edge[i] SHALL be high for exactly one cycle, in the cycle after level[i] goes 0->1, when mode[i] is 01 or 11.
REQ-018 neg_edge[i] SHALL be high for exactly one cycle, in the cycle after level[i] goes 1->0, when mode[i] is 10 or 11.
REQ-019 Latency from the first sampling edge of a stable new input to the edge pulse SHALL be SYNC_STAGES+FILT_CYC cycles.
REQ-020 Mode 00 SHALL suppress edge pulses and evt_pend setting; level tracking SHALL continue, so re-enabling produces no spurious edge.
REQ-021 mode SHALL be sampled in the cycle the edge pulse is generated; no edge history SHALL be retained across a mode change.
REQ-022 evt_pend[i] SHALL set on the cycle pos_edge[i] or neg_edge[i] is asserted and hold until cleared by evt_clr[i].
REQ-023 When evt_clr[i] and a new event coincide in the same cycle, the set SHALL win and evt_pend[i] SHALL remain 1.
REQ-024 irq SHALL follow evt_pend with one cycle of latency.

Reset
REQ-025 When rstn=0 at a clock edge, all synchroniser stages, level, filter counters, pos_edge, neg_edge, evt_pend and irq SHALL be 0.
REQ-026 An input held high through reset SHALL produce one pos_edge after release (mode permitting), because level resets to 0.
REQ-027 A reset asserted mid-filter SHALL discard the partial count; no pending edge SHALL survive reset.

Configuration
REQ-028 Macro EDGE_DETECT_MC_FILT_EN SHALL compile in the glitch filter of REQ-015/016.
REQ-029 Without EDGE_DETECT_MC_FILT_EN, level SHALL equal the synchronised level registered once, the latency SHALL be SYNC_STAGES cycles, no counters SHALL be built, and FILT_CYC SHALL be ignored.

Structure
REQ-030 Package edge_detect_pkg SHALL hold the mode encoding constants (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the parameter limits.
REQ-031 A per-channel sub-module edge_filt SHALL contain the synchroniser, filter and edge registers; the top SHALL generate WIDTH instances plus the evt_pend/irq logic.

Verification
REQ-032 The bench SHALL cover: with defaults and filter on, drive pulse[0] 0->1 and hold -> pos_edge[0] high for 1 cycle exactly 6 cycles after the first sampling edge, and level[0]=1.
REQ-033 The bench SHALL cover: a 3-cycle high glitch on pulse[1] with FILT_CYC=4 -> no pos_edge or neg_edge, and level[1] stays 0; a 4-cycle high pulse -> both edges occur.
REQ-034 The bench SHALL cover: mode[5:4]=10 with a full pulse on channel 2 -> only neg_edge[2]; mode=11 -> both edges; mode=00 -> neither, and evt_pend[2]=0.
REQ-035 The bench SHALL cover: evt_clr[3]=1 in the same cycle as a new edge on channel 3 -> evt_pend[3] stays 1; clear alone -> evt_pend[3]=0 next cycle and irq=0 the cycle after.
REQ-036 The bench SHALL cover: pulse=all ones held through reset -> after release, all outputs are 0 during reset and each channel emits one pos_edge.
REQ-037 The bench SHALL cover: rstn asserted with a filter count at 2 -> count discarded and no edge after release with the input unchanged, apart from the REQ-026 case.
